ex_ctl_pipe: RTL
================

Name: ex_ctl_pipe

Overview:
Parametrised ID/EX pipeline stage for the RV32 core. It decodes the instruction into execute-stage controls and registers them with operands, PC and instruction into a one-entry stage. Versus the fixed-width execute control stage it adds a valid/ready handshake, synchronous flush (bubble insertion), illegal-instruction flagging and an optional M-extension with a multi-cycle divide hold.

Parameters:
XLEN, 32, operand and PC width.
EN_M, 1, 1 = decode RV32M ops; 0 = M ops flagged illegal.
DIV_CYCLES, 32, extra cycles a DIV/DIVU/REM/REMU holds the stage (>=1).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous reset, active-high.
flush  in  1  synchronous kill of stage contents.
in_valid  in  1  decode stage presents an instruction.
in_ready  out  1  stage can accept this cycle (combinational).
data_a, data_b  in  XLEN  register operands.
pc_de  in  XLEN  PC of decoded instruction.
instruction  in  32  raw instruction.
ex_ready  in  1  downstream consumes stage contents.
ex_valid  out  1  stage holds a completed, consumable entry.
ex_busy  out  1  divide hold in progress.
a_sel, b_sel  out  1  0 = data_a / data_b; 1 = PC / immediate.
imm_sel  out  4  0 none, 1 I, 2 S, 3 B, 4 U, 5 J.
sign  out  1  1 when imm_sel is 1, 2, 3 or 5.
pc_sel  out  1  1 for JAL/JALR only.
br_expect  out  3  0 none, 1 BEQ, 2 BNE, 3 BLT, 4 BGE, 5 BLTU, 6 BGEU.
br_un  out  1  1 for BLTU/BGEU.
alu_sel  out  5  AND 00000, OR 00001, XOR 00010, ADD 00011, SUB 00100, PASSB 00110, SLL 00111, SRL 01000, SRA 01010, SLTU 01011, SLT 01100, MUL 10000, MULH 10001, MULHSU 10010, MULHU 10011, DIV 10100, DIVU 10101, REM 10110, REMU 10111.
ex_sys  out  2  01 ECALL, 10 EBREAK, else 00.
ex_illegal  out  1  unrecognised encoding.
data_a_exe, data_b_exe, pc_exe  out  XLEN  registered operands and PC.
instr_exe  out  32  registered instruction.

Behaviour:
- Reset: async, rst high. Outputs go to: ex_valid 0, ex_busy 0, state IDLE, counter 0, a_sel 0, b_sel 1, imm_sel 0, sign 0, pc_sel 0, br_expect 0, br_un 0, alu_sel 00110, ex_sys 0, ex_illegal 0, data/pc 0, instr_exe 0x00000013.
- in_ready = !flush & state==IDLE & (!ex_valid | ex_ready).
- Accept when in_valid & in_ready: all decoded controls and data_a, data_b, pc_de, instruction are registered at that edge. Latency is 1 cycle, so ex_valid=1 after the edge.
- If ex_ready is 1 and nothing is accepted, ex_valid clears to 0. If ex_valid=1 and ex_ready=0, all outputs hold.
- Decode rules:
  - LUI: U, PASSB, b_sel 1.
  - AUIPC: U, ADD, a_sel 1, b_sel 1.
  - JAL (1101111): J, ADD, a_sel 1, b_sel 1, pc_sel 1.
  - JALR (1100111, f3=000): I, ADD, b_sel 1, pc_sel 1.
  - Branches: B, ADD, a_sel 1, b_sel 1, with br_expect per funct3. f3 010/011 are illegal.
  - Loads (f3 000, 001, 010, 100, 101) and stores (f3 000, 001, 010): ADD, I or S immediate.
  - OP-IMM: SLLI needs f7=0. SRLI/SRAI use f7 0000000/0100000.
  - OP: standard f3/f7 decoding, including SRL/SRA.
  - f7=0000001 selects the M ops when EN_M=1.
  - FENCE: a NOP.
  - SYSTEM: instr[31:20]=0 gives ECALL, 1 gives EBREAK, anything else is illegal.
  - Any other encoding: ex_illegal=1, controls at reset defaults, entry still passes with ex_valid=1.
- Divide FSM (IDLE, DIV):
  - Accepting DIV, DIVU, REM or REMU enters DIV. Counter = DIV_CYCLES-1, ex_valid=0, ex_busy=1.
  - In DIV the counter decrements each cycle. At the edge where counter==0: state IDLE, ex_busy 0, ex_valid 1.
  - Result: ex_valid rises DIV_CYCLES cycles later than for a single-cycle op. in_ready=0 throughout DIV.
- Flush has priority over accept, hold and DIV. Next edge: ex_valid 0, ex_busy 0, state IDLE, counter 0, controls to reset defaults, instr_exe 0x00000013. The in_valid entry of that cycle is dropped.
- A flush in the same cycle as the final DIV count still wins: no entry emerges.
- All data paths are XLEN wide; no truncation or extension happens in this block.

Test Plan:
- Reset, then ADDI x1,x0,5 (0x00500093) with in_valid=1, ex_ready=1 -> after 1 edge: ex_valid 1, alu 00011, imm_sel 1, b_sel 1, sign 1, illegal 0.
- BLTU (0x0020E463) -> br_expect 5, br_un 1, imm_sel 3, pc_sel 0. Then JALR (0x000080E7) -> pc_sel 1, imm_sel 1.
- Backpressure: ex_ready=0 with ex_valid=1 -> in_ready 0; outputs stable 3 cycles; ex_ready=1 -> next entry loads.
- DIV (0x0220C0B3), DIV_CYCLES=4 -> ex_busy 1 for 4 cycles, ex_valid 1 on 5th edge, in_ready 0 meanwhile. With EN_M=0 -> ex_illegal 1 after 1 edge.
- flush asserted mid-DIV (counter=2) with in_valid=1 -> next edge ex_valid 0, ex_busy 0, instr_exe 0x00000013, input not taken.
- Async rst pulse between clock edges while ex_valid=1 -> outputs at reset values immediately, before any clock edge.

Source files
------------

// File: rtl/ex_ctl_pipe.sv
// ID/EX stage: decodes an RV32 instruction into execute controls and holds
// them with the operands, PC and instruction in a one-entry stage. Adds a
// valid/ready handshake, flush, illegal flagging and a multi-cycle divide hold.
module ex_ctl_pipe #(
  parameter int XLEN       = 32,
  parameter int EN_M       = 1,
  parameter int DIV_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] data_a,
  input  logic [XLEN-1:0] data_b,
  input  logic [XLEN-1:0] pc_de,
  input  logic [31:0]     instruction,
  input  logic            ex_ready,
  output logic            ex_valid,
  output logic            ex_busy,
  output logic            a_sel,
  output logic            b_sel,
  output logic [3:0]      imm_sel,
  output logic            sign,
  output logic            pc_sel,
  output logic [2:0]      br_expect,
  output logic            br_un,
  output logic [4:0]      alu_sel,
  output logic [1:0]      ex_sys,
  output logic            ex_illegal,
  output logic [XLEN-1:0] data_a_exe,
  output logic [XLEN-1:0] data_b_exe,
  output logic [XLEN-1:0] pc_exe,
  output logic [31:0]     instr_exe
);

  localparam int CNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [4:0] ALU_AND = 5'b00000, ALU_OR = 5'b00001, ALU_XOR = 5'b00010;
  localparam logic [4:0] ALU_ADD = 5'b00011, ALU_SUB = 5'b00100, ALU_PASSB = 5'b00110;
  localparam logic [4:0] ALU_SLL = 5'b00111, ALU_SRL = 5'b01000, ALU_SRA = 5'b01010;
  localparam logic [4:0] ALU_SLTU = 5'b01011, ALU_SLT = 5'b01100;

  localparam logic [3:0] IMM_I = 4'd1, IMM_S = 4'd2, IMM_B = 4'd3, IMM_U = 4'd4, IMM_J = 4'd5;

  typedef struct packed {
    logic       a_sel;
    logic       b_sel;
    logic [3:0] imm_sel;
    logic       sign;
    logic       pc_sel;
    logic [2:0] br_expect;
    logic       br_un;
    logic [4:0] alu_sel;
    logic [1:0] ex_sys;
    logic       ex_illegal;
  } ctl_t;

  localparam ctl_t CTL_RST = '{a_sel: 1'b0, b_sel: 1'b1, imm_sel: 4'd0, sign: 1'b0,
                               pc_sel: 1'b0, br_expect: 3'd0, br_un: 1'b0,
                               alu_sel: ALU_PASSB, ex_sys: 2'b00, ex_illegal: 1'b0};

  typedef enum logic {S_IDLE, S_DIV} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ex_valid_q, ex_valid_d;
  logic              ex_busy_q, ex_busy_d;
  ctl_t              ctl_q, ctl_d;
  logic [XLEN-1:0]   data_a_q, data_a_d, data_b_q, data_b_d, pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;

  ctl_t              dec;
  logic              bad;
  logic              is_div;
  logic              accept;
  logic [6:0]        opc;
  logic [2:0]        f3;
  logic [6:0]        f7;

  assign opc = instruction[6:0];
  assign f3  = instruction[14:12];
  assign f7  = instruction[31:25];

  // Instruction decode; any unrecognised encoding falls back to the idle controls.
  always_comb begin
    dec    = CTL_RST;
    bad    = 1'b0;
    is_div = 1'b0;
    case (opc)
      7'b0110111: dec.imm_sel = IMM_U;
      7'b0010111: begin dec.imm_sel = IMM_U; dec.alu_sel = ALU_ADD; dec.a_sel = 1'b1; end
      7'b1101111: begin
        dec.imm_sel = IMM_J; dec.alu_sel = ALU_ADD; dec.a_sel = 1'b1; dec.pc_sel = 1'b1;
      end
      7'b1100111: begin
        if (f3 == 3'b000) begin
          dec.imm_sel = IMM_I; dec.alu_sel = ALU_ADD; dec.pc_sel = 1'b1;
        end else bad = 1'b1;
      end
      7'b1100011: begin
        dec.imm_sel = IMM_B; dec.alu_sel = ALU_ADD; dec.a_sel = 1'b1;
        case (f3)
          3'b000:  dec.br_expect = 3'd1;
          3'b001:  dec.br_expect = 3'd2;
          3'b100:  dec.br_expect = 3'd3;
          3'b101:  dec.br_expect = 3'd4;
          3'b110:  begin dec.br_expect = 3'd5; dec.br_un = 1'b1; end
          3'b111:  begin dec.br_expect = 3'd6; dec.br_un = 1'b1; end
          default: bad = 1'b1;
        endcase
      end
      7'b0000011: begin
        dec.imm_sel = IMM_I; dec.alu_sel = ALU_ADD;
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) bad = 1'b1;
      end
      7'b0100011: begin
        dec.imm_sel = IMM_S; dec.alu_sel = ALU_ADD;
        if (f3[2] || f3 == 3'b011) bad = 1'b1;
      end
      7'b0010011: begin
        dec.imm_sel = IMM_I;
        case (f3)
          3'b000: dec.alu_sel = ALU_ADD;
          3'b010: dec.alu_sel = ALU_SLT;
          3'b011: dec.alu_sel = ALU_SLTU;
          3'b100: dec.alu_sel = ALU_XOR;
          3'b110: dec.alu_sel = ALU_OR;
          3'b111: dec.alu_sel = ALU_AND;
          3'b001: begin dec.alu_sel = ALU_SLL; bad = (f7 != 7'b0000000); end
          3'b101: begin
            if (f7 == 7'b0000000) dec.alu_sel = ALU_SRL;
            else if (f7 == 7'b0100000) dec.alu_sel = ALU_SRA;
            else bad = 1'b1;
          end
        endcase
      end
      7'b0110011: begin
        dec.b_sel = 1'b0;
        case (f7)
          7'b0000000: begin
            case (f3)
              3'b000: dec.alu_sel = ALU_ADD;
              3'b001: dec.alu_sel = ALU_SLL;
              3'b010: dec.alu_sel = ALU_SLT;
              3'b011: dec.alu_sel = ALU_SLTU;
              3'b100: dec.alu_sel = ALU_XOR;
              3'b101: dec.alu_sel = ALU_SRL;
              3'b110: dec.alu_sel = ALU_OR;
              3'b111: dec.alu_sel = ALU_AND;
            endcase
          end
          7'b0100000: begin
            if (f3 == 3'b000) dec.alu_sel = ALU_SUB;
            else if (f3 == 3'b101) dec.alu_sel = ALU_SRA;
            else bad = 1'b1;
          end
          7'b0000001: begin
            // M ops are 10xxx with funct3 in the low bits; funct3[2] marks the divides.
            if (EN_M != 0) begin
              dec.alu_sel = {2'b10, f3};
              is_div      = f3[2];
            end else bad = 1'b1;
          end
          default: bad = 1'b1;
        endcase
      end
      7'b0001111: ;
      7'b1110011: begin
        if (instruction[31:20] == 12'd0) dec.ex_sys = 2'b01;
        else if (instruction[31:20] == 12'd1) dec.ex_sys = 2'b10;
        else bad = 1'b1;
      end
      default: bad = 1'b1;
    endcase
    dec.sign = (dec.imm_sel == IMM_I) || (dec.imm_sel == IMM_S) ||
               (dec.imm_sel == IMM_B) || (dec.imm_sel == IMM_J);
    if (bad) begin
      dec            = CTL_RST;
      dec.ex_illegal = 1'b1;
      is_div         = 1'b0;
    end
  end

  assign in_ready = !flush && (state_q == S_IDLE) && (!ex_valid_q || ex_ready);
  assign accept   = in_valid && in_ready;

  // Next-state: flush beats the divide hold, which beats accept and drain.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ex_valid_d = ex_valid_q;
    ex_busy_d  = ex_busy_q;
    ctl_d      = ctl_q;
    data_a_d   = data_a_q;
    data_b_d   = data_b_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    if (flush) begin
      state_d    = S_IDLE;
      cnt_d      = '0;
      ex_valid_d = 1'b0;
      ex_busy_d  = 1'b0;
      ctl_d      = CTL_RST;
      data_a_d   = '0;
      data_b_d   = '0;
      pc_d       = '0;
      instr_d    = NOP;
    end else if (state_q == S_DIV) begin
      if (cnt_q == '0) begin
        state_d    = S_IDLE;
        ex_busy_d  = 1'b0;
        ex_valid_d = 1'b1;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end else if (accept) begin
      ctl_d    = dec;
      data_a_d = data_a;
      data_b_d = data_b;
      pc_d     = pc_de;
      instr_d  = instruction;
      if (is_div) begin
        state_d    = S_DIV;
        cnt_d      = CNT_LOAD;
        ex_valid_d = 1'b0;
        ex_busy_d  = 1'b1;
      end else begin
        ex_valid_d = 1'b1;
      end
    end else if (ex_ready) begin
      ex_valid_d = 1'b0;
    end
  end

  // Stage register with the FSM state; every output comes straight from here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      ex_valid_q <= 1'b0;
      ex_busy_q  <= 1'b0;
      ctl_q      <= CTL_RST;
      data_a_q   <= '0;
      data_b_q   <= '0;
      pc_q       <= '0;
      instr_q    <= NOP;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ex_valid_q <= ex_valid_d;
      ex_busy_q  <= ex_busy_d;
      ctl_q      <= ctl_d;
      data_a_q   <= data_a_d;
      data_b_q   <= data_b_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
    end
  end

  assign ex_valid   = ex_valid_q;
  assign ex_busy    = ex_busy_q;
  assign a_sel      = ctl_q.a_sel;
  assign b_sel      = ctl_q.b_sel;
  assign imm_sel    = ctl_q.imm_sel;
  assign sign       = ctl_q.sign;
  assign pc_sel     = ctl_q.pc_sel;
  assign br_expect  = ctl_q.br_expect;
  assign br_un      = ctl_q.br_un;
  assign alu_sel    = ctl_q.alu_sel;
  assign ex_sys     = ctl_q.ex_sys;
  assign ex_illegal = ctl_q.ex_illegal;
  assign data_a_exe = data_a_q;
  assign data_b_exe = data_b_q;
  assign pc_exe     = pc_q;
  assign instr_exe  = instr_q;

endmodule
